// File: rtl/bin_to_bcd.sv
// -----------------------------------------------------------------------------
// bin_to_bcd
//
// Sequential binary-to-BCD converter using shift-add-3 (double dabble). It
// converts a BIN_W-bit unsigned value into four BCD digits (thousands..units).
// The start/ready/done_tick handshake matches bcd_to_binary, so either block can
// sit behind the same control FSM.
//
// Build option:
//   BIN2BCD_OVF_EN - when defined, adds the ovf output. An input above 9999
//                    sets ovf and saturates the result to 9,9,9,9. When it is
//                    not defined, the result is bin mod 10000 with no error flag.
//
// Parameters:
//   BIN_W      width of the binary operand (4..14)
//
// Ports:
//   clk        system clock, all state updates on the rising edge
//   reset      asynchronous reset, active low (0 = in reset)
//   start      conversion request, sampled only while idle
//   bin        binary operand, captured on the accepted start edge
//   ready      high while idle, i.e. a start would be accepted
//   done_tick  one-cycle pulse; digits are valid here and held afterwards
//   bcd3..bcd0 thousands, hundreds, tens and units digits
//   ovf        operand exceeded 9999 (BIN2BCD_OVF_EN only)
// -----------------------------------------------------------------------------
module bin_to_bcd #(
  parameter int BIN_W = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             ready,
  output logic             done_tick,
  output logic [3:0]       bcd3,
  output logic [3:0]       bcd2,
  output logic [3:0]       bcd1,
  output logic [3:0]       bcd0
`ifdef BIN2BCD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BIN_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OP   = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [15:0] BCD_SAT = 16'h9999;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [BIN_W-1:0] shreg;
  logic [15:0]      bcd;

  logic [15:0]      bcd_adj;
  logic [15:0]      bcd_nxt;
  logic [BIN_W-1:0] shreg_nxt;
  logic             sat;

  // Add 3 to a digit that would become >=10 after the following doubling.
  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  function automatic logic [15:0] adjust(input logic [15:0] b);
    return {add3(b[15:12]), add3(b[11:8]), add3(b[7:4]), add3(b[3:0])};
  endfunction

  // Replaces the final shifted digits with 9999 when saturation is requested.
  function automatic logic [15:0] saturate(input logic [15:0] b, input logic s);
    return s ? BCD_SAT : b;
  endfunction

`ifdef BIN2BCD_OVF_EN
  logic ovf_r;
  assign sat = ovf_r;
  assign ovf = ovf_r;
`else
  assign sat = 1'b0;
`endif

  // Adjust-then-shift within one cycle. The top bit of the adjusted thousands
  // digit falls off the end, which is what gives mod-10000 wrap for large inputs.
  always_comb begin
    bcd_adj = adjust(bcd);
    {bcd_nxt, shreg_nxt} = {bcd_adj[14:0], shreg, 1'b0};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      shreg <= '0;
      bcd   <= '0;
`ifdef BIN2BCD_OVF_EN
      ovf_r <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            shreg <= bin;
            bcd   <= '0;
            cnt   <= CNT_LOAD;
            state <= OP;
`ifdef BIN2BCD_OVF_EN
            ovf_r <= (32'(bin) > 32'd9999);
`endif
          end
        end
        OP: begin
          cnt   <= cnt - CNT_LAST;
          shreg <= shreg_nxt;
          if (cnt == CNT_LAST) begin
            // Last shift: saturation is folded in here so DONE already shows it.
            bcd   <= saturate(bcd_nxt, sat);
            state <= DONE;
          end else begin
            bcd   <= bcd_nxt;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign ready     = (state == IDLE);
  assign done_tick = (state == DONE);

  assign bcd3 = bcd[15:12];
  assign bcd2 = bcd[11:8];
  assign bcd1 = bcd[7:4];
  assign bcd0 = bcd[3:0];

endmodule

// File: tb/tb_bin_to_bcd.sv
// -----------------------------------------------------------------------------
// tb_bin_to_bcd
//
// Scoreboard bench for bin_to_bcd. A reference process tracks acceptance and
// busy time as a simple cycles-remaining count and pushes the decimal result
// of each accepted operand; a monitor on the falling edge checks ready,
// done_tick, the result at done_tick and the held digits while idle.
// Define BIN2BCD_OVF_EN for both RTL and bench to cover the overflow option.
// -----------------------------------------------------------------------------
module tb_bin_to_bcd;

  localparam int BIN_W = 14;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [BIN_W-1:0] bin = '0;
  logic             ready;
  logic             done_tick;
  logic [3:0]       bcd3, bcd2, bcd1, bcd0;
`ifdef BIN2BCD_OVF_EN
  logic             ovf;
`endif

  bin_to_bcd #(.BIN_W(BIN_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bin       (bin),
    .ready     (ready),
    .done_tick (done_tick),
    .bcd3      (bcd3),
    .bcd2      (bcd2),
    .bcd1      (bcd1),
    .bcd0      (bcd0)
`ifdef BIN2BCD_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] dig;
    logic        ovf;
  } exp_t;

  exp_t        sb[$];
  int          busy_left = 0;
  logic [15:0] hold_dig = '0;
  logic        hold_ovf = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;

  // Decimal result from plain arithmetic.
  function automatic exp_t ref_conv(input int v);
    exp_t e;
    int   val;
    val   = v % 10000;
    e.ovf = 1'b0;
`ifdef BIN2BCD_OVF_EN
    if (v > 9999) begin
      val   = 9999;
      e.ovf = 1'b1;
    end
`endif
    e.dig = {4'(val / 1000), 4'((val / 100) % 10), 4'((val / 10) % 10), 4'(val % 10)};
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference: a start seen while idle is accepted and keeps the block busy
  // for BIN_W shift cycles plus one done cycle.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_left = 0;
      sb.delete();
      hold_dig = '0;
      hold_ovf = 1'b0;
    end else if (busy_left == 0) begin
      if (start) begin
        sb.push_back(ref_conv(int'(bin)));
        busy_left = BIN_W + 1;
      end
    end else begin
      busy_left--;
    end
  end

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    chk("ready", 32'(ready), 32'(busy_left == 0));
    chk("done_tick", 32'(done_tick), 32'(busy_left == 1));
    if (done_tick === 1'b1) begin
      if (sb.size() == 0) begin
        chk("done_without_start", 32'(done_tick), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("digits", 32'({bcd3, bcd2, bcd1, bcd0}), 32'(e.dig));
`ifdef BIN2BCD_OVF_EN
        chk("ovf", 32'(ovf), 32'(e.ovf));
`endif
        hold_dig = e.dig;
        hold_ovf = e.ovf;
      end
    end else if (busy_left == 0) begin
      chk("held_digits", 32'({bcd3, bcd2, bcd1, bcd0}), 32'(hold_dig));
`ifdef BIN2BCD_OVF_EN
      chk("held_ovf", 32'(ovf), 32'(hold_ovf));
`endif
    end
  end

  // Called at a falling edge; returns at a falling edge once idle.
  task automatic wait_idle();
    int t = 0;
    while (busy_left != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (busy_left != 0) chk("idle_timeout", 32'(busy_left), 32'd0);
  endtask

  task automatic go(input int v, input int gap);
    wait_idle();
    bin   = BIN_W'(v);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk);
    #2 reset = 1'b1;
    @(negedge clk);

    // Directed conversions
    go(1002, 0);
    go(9999, 0);
    go(0, 0);
    go(58, 0);

    // Second start during a conversion must be ignored
    go(1234, 3);
    bin   = BIN_W'(4321);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;

    // Reset in the middle of a conversion, then a fresh one
    go(777, 4);
    @(posedge clk);
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    go(777, 0);

    // Above-range operand, then a normal one
    go(12000, 0);
    go(500, 0);
    wait_idle();
    repeat (2) @(negedge clk);

    // Start held high, operand alternating each accepted start
    start = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_idle();
      bin = (k % 2 == 0) ? BIN_W'(4095) : BIN_W'(16);
      @(negedge clk);
    end
    start = 1'b0;

    // Random operands, gaps and stray starts while busy
    for (int k = 0; k < 40; k++) begin
      go(int'($urandom_range(0, (1 << BIN_W) - 1)), int'($urandom_range(0, 6)));
      if ($urandom_range(0, 2) == 0) begin
        bin   = BIN_W'($urandom);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    end

    wait_idle();
    repeat (3) @(negedge clk);
    chk("pending_results", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
